// File: rtl/frame_pkg.sv
// Shared constants and FSM state encodings for the frame ping-pong buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro: FRAME_CHECKSUM_EN (adds a 16-bit sum word after each frame).
package frame_pkg;

    localparam int FRAME_WORDS = 130;   // [0]=channel, [1..128]=samples, [129]=peak count
    localparam int AW          = 8;     // bank address width
    localparam int DW          = 16;    // word width

`ifdef FRAME_CHECKSUM_EN
    localparam int STREAM_WORDS = FRAME_WORDS + 1;  // checksum word appended at FRAME_WORDS
`else
    localparam int STREAM_WORDS = FRAME_WORDS;
`endif

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_SKIP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_PRIME  = 2'd1,
        R_STREAM = 2'd2
    } rstate_t;

endpackage

// File: rtl/dp_ram_sdp.sv
// Simple dual-port RAM holding both frame banks; bank select is the address MSB.
// Latency: synchronous write, one-cycle registered read (rdata updates only when re=1).
// Backpressure: none; holding re low keeps rdata stable, which the reader uses to stall.
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata registered read data.
module dp_ram_sdp #(
    parameter int ADDR_W = frame_pkg::AW,
    parameter int DATA_W = frame_pkg::DW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W:0]   raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_pingpong_buf.sv
// Two-bank ping-pong buffer: captures wr_ram_flag-strobed frames, replays them on a valid/ready stream.
// Latency: frame readable the cycle after its last word lands; first rd_valid two cycles after that.
// Backpressure: rd_ready low freezes rd_data/rd_sof/rd_eof; frames arriving with both banks full are dropped.
// Ports: clk_25m, rst_n (async active-low); data_in/wr_ram_flag write side; rd_ready/rd_valid/rd_data/
//        rd_sof/rd_eof read stream; drop_cnt (saturating) and err_short (sticky) status.
// Optional feature macro: FRAME_CHECKSUM_EN appends a mod-2^16 sum of the frame as the final word.
module frame_pingpong_buf
    import frame_pkg::*;
(
    input  logic          clk_25m,
    input  logic          rst_n,
    input  logic [DW-1:0] data_in,
    input  logic          wr_ram_flag,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_sof,
    output logic          rd_eof,
    output logic [7:0]    drop_cnt,
    output logic          err_short
);

    localparam logic [AW-1:0] FW_A   = AW'(FRAME_WORDS);
    localparam logic [AW-1:0] LAST_A = AW'(STREAM_WORDS - 1);

    wstate_t       w_state, w_state_nxt;
    rstate_t       r_state, r_state_nxt;
    logic          flag_d;
    logic          flag_rise;
    logic [1:0]    full, full_nxt;
    logic          wbank, rbank;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] ridx, ridx_inc;

    logic          wbank_avail;
    logic          wr_start, wr_adv, wr_done, wr_short, wr_drop;
    logic          rd_release, rd_adv;

    logic          ram_we, ram_re;
    logic [AW:0]   ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_q;

`ifdef FRAME_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    assign flag_rise = wr_ram_flag && !flag_d;
    assign ridx_inc  = ridx + 1'b1;

    // Banks fill and drain in the same order, so the write bank is the only
    // candidate. A bank released by the reader this very cycle counts as free.
    assign wbank_avail = !full[wbank] || (rd_release && (rbank == wbank));

    // ---------------- write FSM ----------------
    always_comb begin
        w_state_nxt = w_state;
        ram_we      = 1'b0;
        ram_waddr   = {wbank, wcnt};
        ram_wdata   = data_in;
        wr_start    = 1'b0;
        wr_adv      = 1'b0;
        wr_done     = 1'b0;
        wr_short    = 1'b0;
        wr_drop     = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (flag_rise) begin
                    if (wbank_avail) begin
                        w_state_nxt = W_FILL;
                        ram_we      = 1'b1;
                        ram_waddr   = {wbank, {AW{1'b0}}};
                        wr_start    = 1'b1;
                    end else begin
                        w_state_nxt = W_SKIP;
                        wr_drop     = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (wr_ram_flag) begin
                    // Words past the frame length are ignored; wcnt parks at FW_A.
                    if (wcnt != FW_A) begin
                        ram_we = 1'b1;
                        wr_adv = 1'b1;
                    end
                end else begin
                    w_state_nxt = W_IDLE;
                    if (wcnt == FW_A) begin
                        wr_done = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        // Write port is idle on the falling-flag cycle: drop the sum in.
                        ram_we    = 1'b1;
                        ram_waddr = {wbank, FW_A};
                        ram_wdata = csum;
`endif
                    end else begin
                        wr_short = 1'b1;
                    end
                end
            end
            W_SKIP: begin
                if (!wr_ram_flag) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // ---------------- read FSM ----------------
    always_comb begin
        r_state_nxt = r_state;
        rd_valid    = 1'b0;
        ram_re      = 1'b0;
        ram_raddr   = {rbank, ridx_inc};
        rd_release  = 1'b0;
        rd_adv      = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (full[rbank]) begin
                    r_state_nxt = R_PRIME;
                end
            end
            R_PRIME: begin
                ram_re      = 1'b1;
                ram_raddr   = {rbank, {AW{1'b0}}};
                r_state_nxt = R_STREAM;
            end
            R_STREAM: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    if (ridx == LAST_A) begin
                        rd_release  = 1'b1;
                        r_state_nxt = R_IDLE;
                    end else begin
                        // Fetch the next word on the accept so it is on rd_data next cycle.
                        ram_re = 1'b1;
                        rd_adv = 1'b1;
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wbank] = 1'b1;
        end
        if (rd_release) begin
            full_nxt[rbank] = 1'b0;
        end
    end

    assign rd_data = rd_valid ? ram_q : '0;
    assign rd_sof  = rd_valid && (ridx == '0);
    assign rd_eof  = rd_valid && (ridx == LAST_A);

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            flag_d    <= 1'b0;
            full      <= 2'b00;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            wcnt      <= '0;
            ridx      <= '0;
            drop_cnt  <= 8'd0;
            err_short <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
            flag_d  <= wr_ram_flag;
            full    <= full_nxt;
            if (wr_done) begin
                wbank <= ~wbank;
            end
            if (rd_release) begin
                rbank <= ~rbank;
            end
            if (wr_start) begin
                wcnt <= AW'(1);
            end else if (wr_adv) begin
                wcnt <= wcnt + 1'b1;
            end
            if (wr_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (wr_short) begin
                err_short <= 1'b1;
            end
            if (r_state == R_PRIME) begin
                ridx <= '0;
            end else if (rd_adv) begin
                ridx <= ridx_inc;
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (wr_start) begin
            csum <= data_in;
        end else if (wr_adv) begin
            csum <= csum + data_in;
        end
    end
`endif

    dp_ram_sdp #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) u_ram (
        .clk   (clk_25m),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_frame_pingpong_buf.sv
// Directed bench for frame_pingpong_buf: single frame, backpressure, overflow, short frame, reset mid-frame.
// Latency: n/a.
// Backpressure: rd_ready driven by the bench (steady level or toggling every cycle).
module tb_frame_pingpong_buf;

`ifdef FRAME_CHECKSUM_EN
    localparam int LEN = 131;
`else
    localparam int LEN = 130;
`endif

    logic        clk_25m;
    logic        rst_n;
    logic [15:0] data_in;
    logic        wr_ram_flag;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_sof;
    logic        rd_eof;
    logic [7:0]  drop_cnt;
    logic        err_short;

    int tests_run = 0;
    int fails     = 0;

    logic        toggle_en   = 1'b0;
    logic        ready_level = 1'b1;

    logic [17:0] rxq [$];
    logic        stall_pend = 1'b0;
    logic [17:0] held       = '0;
    int          stall_err  = 0;
    int          stall_cnt  = 0;

    frame_pingpong_buf dut (
        .clk_25m     (clk_25m),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_ram_flag (wr_ram_flag),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_sof      (rd_sof),
        .rd_eof      (rd_eof),
        .drop_cnt    (drop_cnt),
        .err_short   (err_short)
    );

    initial begin
        clk_25m = 1'b0;
        forever #20 clk_25m = ~clk_25m;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // rd_ready driver: steady level, or toggling every cycle when toggle_en is set.
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk_25m);
            #1;
            rd_ready = toggle_en ? ~rd_ready : ready_level;
        end
    end

    // Output monitor: log accepted words, and confirm a stalled word is held unchanged.
    always @(negedge clk_25m) begin
        if (stall_pend && (!rd_valid || ({rd_sof, rd_eof, rd_data} != held))) begin
            stall_err++;
        end
        if (rd_valid && rd_ready) begin
            rxq.push_back({rd_sof, rd_eof, rd_data});
        end
        stall_pend = rd_valid && !rd_ready;
        held       = {rd_sof, rd_eof, rd_data};
        if (stall_pend) begin
            stall_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int ch, input int i);
        if (i == 0)   return 16'(ch);
        if (i == 129) return 16'd128;
        if (i == 130) return 16'(ch + 8256 + 128);
        return 16'(i);
    endfunction

    // Drive nwords flag-high cycles; optionally pull rst_n low at word rst_at.
    task automatic send_frame(input int ch, input int nwords, input int rst_at);
        for (int i = 0; i < nwords; i++) begin
            @(posedge clk_25m);
            #1;
            if (i == rst_at) rst_n = 1'b0;
            wr_ram_flag = 1'b1;
            data_in     = exp_word(ch, i);
        end
        @(posedge clk_25m);
        #1;
        wr_ram_flag = 1'b0;
        data_in     = '0;
        repeat (2) @(posedge clk_25m);
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k = 0;
        while ((rxq.size() < n) && (k < budget)) begin
            @(posedge clk_25m);
            k++;
        end
        check({tag, "_count_reached"}, 32'(rxq.size() >= n), 32'd1);
    endtask

    task automatic expect_frame(input int ch, input string tag);
        logic [17:0] item;
        logic [17:0] exp;
        for (int i = 0; i < LEN; i++) begin
            item = (rxq.size() > 0) ? rxq.pop_front() : 18'h3FFFF;
            exp  = {(i == 0), (i == LEN - 1), exp_word(ch, i)};
            check($sformatf("%s_w%0d", tag, i), 32'(item), 32'(exp));
        end
    endtask

    task automatic expect_silence(input int cycles, input string tag);
        repeat (cycles) @(posedge clk_25m);
        check(tag, 32'(rxq.size()), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_ram_flag = 1'b0;
        data_in     = '0;
        repeat (3) @(posedge clk_25m);
        @(negedge clk_25m);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data",  32'(rd_data),  32'd0);
        check("rst_sof",   32'(rd_sof),   32'd0);
        check("rst_eof",   32'(rd_eof),   32'd0);
        check("rst_drop",  32'(drop_cnt), 32'd0);
        check("rst_err",   32'(err_short), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_25m);

        // T1 single frame, rd_ready held high
        send_frame(3, 130, -1);
        wait_words(LEN, 400, "t1");
        expect_frame(3, "t1");
        check("t1_drop", 32'(drop_cnt), 32'd0);
        expect_silence(20, "t1_no_extra");

        // T2 backpressure: rd_ready toggles every cycle
        toggle_en = 1'b1;
        send_frame(3, 130, -1);
        wait_words(LEN, 800, "t2");
        expect_frame(3, "t2");
        toggle_en   = 1'b0;
        ready_level = 1'b1;
        check("t2_stalls_seen", 32'(stall_cnt > 0), 32'd1);
        check("t2_stable_on_stall", 32'(stall_err), 32'd0);
        expect_silence(20, "t2_no_extra");

        // T3 overflow: three frames with no reader, third must be dropped
        ready_level = 1'b0;
        repeat (2) @(posedge clk_25m);
        send_frame(5, 130, -1);
        send_frame(6, 130, -1);
        send_frame(7, 130, -1);
        @(negedge clk_25m);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        check("t3_valid_waiting", 32'(rd_valid), 32'd1);
        check("t3_nothing_accepted", 32'(rxq.size()), 32'd0);
        ready_level = 1'b1;
        wait_words(2 * LEN, 800, "t3");
        expect_frame(5, "t3a");
        expect_frame(6, "t3b");
        expect_silence(300, "t3_frame3_absent");

        // T4 short frame: 60 words, then a full frame
        send_frame(9, 60, -1);
        @(negedge clk_25m);
        check("t4_err_short", 32'(err_short), 32'd1);
        expect_silence(200, "t4_short_not_output");
        send_frame(10, 130, -1);
        wait_words(LEN, 400, "t4");
        expect_frame(10, "t4");
        check("t4_err_sticky", 32'(err_short), 32'd1);

        // T5 reset asserted at word 70 of a frame
        send_frame(11, 130, 70);
        @(negedge clk_25m);
        check("t5_valid",  32'(rd_valid),  32'd0);
        check("t5_data",   32'(rd_data),   32'd0);
        check("t5_drop",   32'(drop_cnt),  32'd0);
        check("t5_err",    32'(err_short), 32'd0);
        rst_n = 1'b1;
        expect_silence(300, "t5_no_output");
        send_frame(12, 130, -1);
        wait_words(LEN, 400, "t5");
        expect_frame(12, "t5");
        expect_silence(20, "t5_no_extra");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
